usart_rx_fifo: RTL and testbench
================================

Name: usart_rx_fifo

Overview:
- Oversampling 8N1 USART receiver with a receive FIFO.
- Sits directly downstream of the board's rx pin and upstream of the echo/transmit path.
- Converts the asynchronous serial stream into bytes, offered on a valid/ready interface.
- Bit timing comes from the same runtime clock_divider scheme as the transmit side: divider sets the x16 tick, 16 ticks per bit.

Parameters:
- FIFO_ADDR_WIDTH, 4, log2 of FIFO depth; depth = 2**FIFO_ADDR_WIDTH = 16.
- DIVIDER_WIDTH, 12, width of clock_divider.

Ports:
- comm_clock  input  1  single block clock; every register is clocked on its rising edge.
- comm_reset  input  1  synchronous, active-high reset.
- clock_divider  input  DIVIDER_WIDTH  comm_clock cycles per x16 oversample tick; 0 is treated as 1.
- rx_pin  input  1  asynchronous serial line; idle high.
- rx_data  output  8  byte at FIFO head.
- rx_valid  output  1  FIFO non-empty.
- rx_ready  input  1  consumer accepts rx_data this cycle.
- fifo_count  output  FIFO_ADDR_WIDTH+1  bytes held, 0..16.
- rx_busy  output  1  high while a frame is being received (state != IDLE).
- framing_error  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun_error  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Behaviour:
- Reset: FSM=IDLE; FIFO empty. Outputs: rx_valid=0, fifo_count=0, rx_data=0, rx_busy=0, framing_error=0, overrun_error=0. Synchroniser flops preset to 1.
- Reset asserted mid-frame: the partial byte is discarded and nothing is pushed.
- Synchroniser: rx_pin passes through 2 flops; FSM uses only the synchronised value (rx_s).
- Tick generator:
  - Counter runs 0..max(clock_divider,1)-1; tick asserts for one cycle when the counter equals the terminal value.
  - Counter and sample index (0..15) clear on the IDLE->START transition, so tick phase is aligned to the start edge.
  - clock_divider is sampled continuously; changing it mid-frame is undefined.
- Sampling: in each bit window the samples at ticks 7, 8 and 9 are captured; bit value = majority of the three.
- FSM:
  - IDLE: rx_s==0 -> START.
  - START: at tick 9, majority=1 -> IDLE (glitch rejected, no flag); majority=0 -> continue. At tick 15 -> DATA with bit_cnt=0.
  - DATA: 8 windows, LSB first. The bit is shifted into the shift register at tick 9. At tick 15 of bit 7 -> STOP.
  - STOP: at tick 9, majority=1 -> push byte -> IDLE. Majority=0 -> framing_error pulse, byte discarded -> RECOVER.
  - RECOVER: wait for rx_s==1 -> IDLE. A break condition produces exactly one framing_error.
- Returning to IDLE at stop-bit tick 9 gives resynchronisation margin for back-to-back frames.
- FIFO:
  - 16-entry circular buffer with FIFO_ADDR_WIDTH-bit pointers that wrap at 16.
  - fifo_count is a separate counter.
  - rx_data = mem[rd_ptr] (show-ahead); rx_valid = (fifo_count != 0).
  - Pop when rx_valid && rx_ready; rx_ready while empty is ignored.
  - Push on a good stop bit:
    - count < 16: write, count+1.
    - count == 16 with no pop that cycle: byte dropped, overrun_error pulse, FIFO contents unchanged.
    - count == 16 with a pop that cycle: push accepted, count stays 16, no overrun.
  - Simultaneous push and pop with count in 1..15: count unchanged, both pointers advance.
  - Empty with push: rx_valid and rx_data are valid from the cycle after the push cycle.
- Error pulses: each is exactly one comm_clock cycle wide and independent of rx_ready.

Test Plan:
- Basic frame: clock_divider=2 (32 clocks/bit), send 0xA5 8N1, rx_ready=0. Required: after the stop sample, rx_valid=1, rx_data=0xA5, fifo_count=1. Then rx_ready=1 for one cycle -> rx_valid=0, fifo_count=0.
- Glitch rejection: rx_pin low for 3 clocks (under 2 ticks at divider=2), then high. Required: rx_busy returns to 0 at START tick 9; no push, no error pulse.
- Framing/break: send 0x3C with stop bit low, line held low for 40 bit times. Required: exactly one framing_error pulse, fifo_count=0, no further frames until the line returns high. A following 0x55 is then received correctly.
- Overrun: 17 back-to-back bytes 0x00..0x10, rx_ready=0. Required: fifo_count=16, one overrun_error pulse on the 17th byte, and draining yields 0x00..0x0F in order.
- Full push+pop: FIFO full, rx_ready=1 in the exact cycle the 17th byte pushes. Required: no overrun, fifo_count stays 16, and the drained order ends with the new byte.
- Reset mid-frame: assert comm_reset for 1 cycle during DATA bit 4 of 0xFF. Required: all outputs at reset values, no byte pushed; the next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/usart_rx_fifo.sv
// usart_rx_fifo: oversampling 8N1 receiver feeding a 16-entry show-ahead FIFO.
// The line is oversampled at x16 (tick rate set by clock_divider); each bit is
// decided by a 2-of-3 vote over ticks 7, 8 and 9 of its window.
module usart_rx_fifo #(
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int DIVIDER_WIDTH   = 12
) (
    input  logic                       comm_clock,
    input  logic                       comm_reset,
    input  logic [DIVIDER_WIDTH-1:0]   clock_divider,
    input  logic                       rx_pin,
    output logic [7:0]                 rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_count,
    output logic                       rx_busy,
    output logic                       framing_error,
    output logic                       overrun_error
);

    localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
    localparam logic [FIFO_ADDR_WIDTH:0]   FULL_COUNT = DEPTH[FIFO_ADDR_WIDTH:0];
    localparam logic [FIFO_ADDR_WIDTH:0]   CNT_ZERO   = {(FIFO_ADDR_WIDTH+1){1'b0}};
    localparam logic [FIFO_ADDR_WIDTH:0]   CNT_ONE    = {{FIFO_ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ZERO   = {FIFO_ADDR_WIDTH{1'b0}};
    localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE    = {{(FIFO_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIVIDER_WIDTH-1:0]   DIV_ZERO   = {DIVIDER_WIDTH{1'b0}};
    localparam logic [DIVIDER_WIDTH-1:0]   DIV_ONE    = {{(DIVIDER_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_RECOVER = 3'd4
    } rx_state_t;

    // 2-of-3 vote used to decide each bit value
    function automatic logic majority3(input logic a, input logic b, input logic c);
        majority3 = (a & b) | (a & c) | (b & c);
    endfunction

    // synchroniser
    logic                       rx_meta_r;
    logic                       rx_sync_r;

    // tick generator
    logic [DIVIDER_WIDTH-1:0]   div_cnt_r;
    logic [DIVIDER_WIDTH-1:0]   div_term_s;
    logic [3:0]                 samp_idx_r;
    logic                       tick_s;

    // receive datapath
    logic                       samp7_r;
    logic                       samp8_r;
    logic                       maj_s;
    logic [2:0]                 bit_cnt_r;
    logic [2:0]                 bit_cnt_next_s;
    logic [7:0]                 shift_r;
    logic [7:0]                 shift_next_s;

    // FSM
    rx_state_t                  state_r;
    rx_state_t                  state_next_s;
    logic                       start_s;
    logic                       push_s;
    logic                       ferr_s;

    // FIFO
    logic [7:0]                 mem_r [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_r;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_r;
    logic [FIFO_ADDR_WIDTH:0]   count_r;
    logic [FIFO_ADDR_WIDTH:0]   count_next_s;
    logic                       pop_s;
    logic                       full_s;
    logic                       wr_en_s;
    logic                       overrun_s;

    // registered status outputs
    logic                       rx_valid_r;
    logic                       rx_busy_r;
    logic                       framing_error_r;
    logic                       overrun_error_r;

    // Two-flop synchroniser; preset high so reset looks like an idle line
    always_ff @(posedge comm_clock) begin
        if (comm_reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_pin;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Terminal count of the tick divider; a divider of 0 behaves like 1
    always_comb begin
        div_term_s = DIV_ZERO;
        if (clock_divider == DIV_ZERO) begin
            div_term_s = DIV_ZERO;
        end else begin
            div_term_s = clock_divider - DIV_ONE;
        end
        // >= keeps the counter from running away if the divider shrinks
        tick_s = (div_cnt_r >= div_term_s);
        maj_s  = majority3(samp7_r, samp8_r, rx_sync_r);
    end

    // x16 tick counter and sample index, phase-aligned to the start edge
    always_ff @(posedge comm_clock) begin
        if (comm_reset || start_s) begin
            div_cnt_r  <= DIV_ZERO;
            samp_idx_r <= 4'd0;
        end else if (tick_s) begin
            div_cnt_r  <= DIV_ZERO;
            samp_idx_r <= samp_idx_r + 4'd1;
        end else begin
            div_cnt_r  <= div_cnt_r + DIV_ONE;
            samp_idx_r <= samp_idx_r;
        end
    end

    // Capture the first two votes of each bit window; the third is live
    always_ff @(posedge comm_clock) begin
        if (comm_reset) begin
            samp7_r <= 1'b1;
            samp8_r <= 1'b1;
        end else if (tick_s && (samp_idx_r == 4'd7)) begin
            samp7_r <= rx_sync_r;
        end else if (tick_s && (samp_idx_r == 4'd8)) begin
            samp8_r <= rx_sync_r;
        end else begin
            samp7_r <= samp7_r;
            samp8_r <= samp8_r;
        end
    end

    // FSM state register and frame datapath registers
    always_ff @(posedge comm_clock) begin
        if (comm_reset) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            state_r   <= state_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            shift_r   <= shift_next_s;
        end
    end

    // FSM next-state, bit shifting and push/error strobes
    always_comb begin
        state_next_s   = state_r;
        start_s        = 1'b0;
        push_s         = 1'b0;
        ferr_s         = 1'b0;
        bit_cnt_next_s = bit_cnt_r;
        shift_next_s   = shift_r;
        case (state_r)
            ST_IDLE: begin
                if (!rx_sync_r) begin
                    state_next_s = ST_START;
                    start_s      = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && (samp_idx_r == 4'd9) && maj_s) begin
                    // start bit did not hold low: treat as a glitch
                    state_next_s = ST_IDLE;
                end else if (tick_s && (samp_idx_r == 4'd15)) begin
                    state_next_s   = ST_DATA;
                    bit_cnt_next_s = 3'd0;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s && (samp_idx_r == 4'd9)) begin
                    shift_next_s = {maj_s, shift_r[7:1]};
                end else if (tick_s && (samp_idx_r == 4'd15)) begin
                    if (bit_cnt_r == 3'd7) begin
                        state_next_s = ST_STOP;
                    end else begin
                        bit_cnt_next_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_STOP: begin
                // leave at tick 9 so a back-to-back start edge is not missed
                if (tick_s && (samp_idx_r == 4'd9)) begin
                    if (maj_s) begin
                        push_s       = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        ferr_s       = 1'b1;
                        state_next_s = ST_RECOVER;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_RECOVER: begin
                // a held-low line (break) yields a single framing error
                if (rx_sync_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RECOVER;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FIFO control: push/pop arbitration, overrun detection, next count
    always_comb begin
        pop_s        = rx_valid_r & rx_ready;
        full_s       = (count_r == FULL_COUNT);
        wr_en_s      = push_s & (~full_s | pop_s);
        overrun_s    = push_s & full_s & ~pop_s;
        count_next_s = count_r;
        if (wr_en_s && !pop_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (pop_s && !wr_en_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // FIFO storage, pointers and count
    always_ff @(posedge comm_clock) begin
        if (comm_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            rx_valid_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= shift_r;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r    <= count_next_s;
            rx_valid_r <= (count_next_s != CNT_ZERO);
        end
    end

    // Registered status and single-cycle error pulses
    always_ff @(posedge comm_clock) begin
        if (comm_reset) begin
            rx_busy_r       <= 1'b0;
            framing_error_r <= 1'b0;
            overrun_error_r <= 1'b0;
        end else begin
            rx_busy_r       <= (state_next_s != ST_IDLE);
            framing_error_r <= ferr_s;
            overrun_error_r <= overrun_s;
        end
    end

    assign rx_data       = mem_r[rd_ptr_r];
    assign rx_valid      = rx_valid_r;
    assign fifo_count    = count_r;
    assign rx_busy       = rx_busy_r;
    assign framing_error = framing_error_r;
    assign overrun_error = overrun_error_r;

endmodule

// File: tb/tb_usart_rx_fifo.sv
// Self-checking bench for usart_rx_fifo: a frame table plus hand-written
// multi-cycle sequences; received bytes are checked against a scoreboard queue.
module tb_usart_rx_fifo;

    logic        comm_clock = 1'b0;
    logic        comm_reset;
    logic [11:0] clock_divider;
    logic        rx_pin;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [4:0]  fifo_count;
    logic        rx_busy;
    logic        framing_error;
    logic        overrun_error;

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [11:0] div;
        logic [7:0]  data;
        logic        stop;
        int          exp_count;
        int          exp_ferr;
    } vec_t;

    vec_t vecs[6];

    usart_rx_fifo #(.FIFO_ADDR_WIDTH(4), .DIVIDER_WIDTH(12)) dut (
        .comm_clock    (comm_clock),
        .comm_reset    (comm_reset),
        .clock_divider (clock_divider),
        .rx_pin        (rx_pin),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .fifo_count    (fifo_count),
        .rx_busy       (rx_busy),
        .framing_error (framing_error),
        .overrun_error (overrun_error)
    );

    always #5 comm_clock = ~comm_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge comm_clock);
        #2;
    endtask

    task automatic idle_bits(input int n, input int bitclk);
        rx_pin = 1'b1;
        repeat (n * bitclk) step();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bitclk);
        rx_pin = 1'b0;
        repeat (bitclk) step();
        for (int i = 0; i < 8; i++) begin
            rx_pin = d[i];
            repeat (bitclk) step();
        end
        rx_pin = stop;
        repeat (bitclk) step();
    endtask

    task automatic drain(input int n);
        rx_ready = 1'b1;
        repeat (n) step();
        rx_ready = 1'b0;
    endtask

    // monitor: count error-pulse cycles and score every pop against the queue
    always @(negedge comm_clock) begin
        if (framing_error === 1'b1) ferr_cnt++;
        if (overrun_error === 1'b1) ovr_cnt++;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", {24'h0, rx_data}, 32'hFFFF_FFFF);
            end else begin
                check("pop_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // bound on total run time
    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f0;
        int o0;
        int bitclk;

        vecs[0] = '{div: 12'd2, data: 8'h00, stop: 1'b1, exp_count: 1, exp_ferr: 0};
        vecs[1] = '{div: 12'd2, data: 8'hFF, stop: 1'b1, exp_count: 1, exp_ferr: 0};
        vecs[2] = '{div: 12'd0, data: 8'h5A, stop: 1'b1, exp_count: 1, exp_ferr: 0};
        vecs[3] = '{div: 12'd1, data: 8'h81, stop: 1'b1, exp_count: 1, exp_ferr: 0};
        vecs[4] = '{div: 12'd3, data: 8'hC3, stop: 1'b1, exp_count: 1, exp_ferr: 0};
        vecs[5] = '{div: 12'd2, data: 8'h96, stop: 1'b0, exp_count: 0, exp_ferr: 1};

        comm_reset    = 1'b1;
        clock_divider = 12'd2;
        rx_pin        = 1'b1;
        rx_ready      = 1'b0;
        repeat (3) step();
        comm_reset = 1'b0;
        @(negedge comm_clock);
        check("rst_valid", {31'h0, rx_valid}, 32'h0);
        check("rst_count", {27'h0, fifo_count}, 32'h0);
        check("rst_data", {24'h0, rx_data}, 32'h0);
        check("rst_busy", {31'h0, rx_busy}, 32'h0);
        check("rst_ferr", {31'h0, framing_error}, 32'h0);
        check("rst_ovr", {31'h0, overrun_error}, 32'h0);
        step();

        // basic frame 0xA5 at divider 2
        idle_bits(1, 32);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 32);
        idle_bits(1, 32);
        check("basic_valid", {31'h0, rx_valid}, 32'h1);
        check("basic_data", {24'h0, rx_data}, 32'hA5);
        check("basic_count", {27'h0, fifo_count}, 32'h1);
        drain(1);
        check("basic_valid_after", {31'h0, rx_valid}, 32'h0);
        check("basic_count_after", {27'h0, fifo_count}, 32'h0);

        // glitch: 3 clocks low
        f0 = ferr_cnt;
        rx_pin = 1'b0;
        repeat (3) step();
        rx_pin = 1'b1;
        step();
        check("glitch_busy_high", {31'h0, rx_busy}, 32'h1);
        repeat (40) step();
        check("glitch_busy_low", {31'h0, rx_busy}, 32'h0);
        check("glitch_count", {27'h0, fifo_count}, 32'h0);
        check("glitch_ferr", f0 - ferr_cnt, 32'h0);

        // frame table
        for (int v = 0; v < 6; v++) begin
            clock_divider = vecs[v].div;
            bitclk = 16 * ((vecs[v].div == 12'd0) ? 1 : int'(vecs[v].div));
            idle_bits(2, bitclk);
            f0 = ferr_cnt;
            if (vecs[v].stop) exp_q.push_back(vecs[v].data);
            send_frame(vecs[v].data, vecs[v].stop, bitclk);
            idle_bits(1, bitclk);
            check("vec_count", {27'h0, fifo_count}, vecs[v].exp_count);
            check("vec_ferr", ferr_cnt - f0, vecs[v].exp_ferr);
            if (vecs[v].exp_count == 1) begin
                check("vec_data", {24'h0, rx_data}, {24'h0, vecs[v].data});
            end
            drain(2);
            check("vec_count_drained", {27'h0, fifo_count}, 32'h0);
        end

        // framing error followed by a 40-bit break
        clock_divider = 12'd2;
        idle_bits(2, 32);
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 32);
        repeat (40 * 32) step();
        check("break_busy", {31'h0, rx_busy}, 32'h1);
        check("break_count", {27'h0, fifo_count}, 32'h0);
        idle_bits(2, 32);
        check("break_busy_released", {31'h0, rx_busy}, 32'h0);
        check("break_ferr", ferr_cnt - f0, 32'h1);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 32);
        idle_bits(1, 32);
        check("after_break_count", {27'h0, fifo_count}, 32'h1);
        check("after_break_data", {24'h0, rx_data}, 32'h55);
        drain(2);

        // overrun: 17 back-to-back bytes, no consumer
        o0 = ovr_cnt;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 32);
        end
        idle_bits(1, 32);
        check("ovr_count", {27'h0, fifo_count}, 32'd16);
        check("ovr_pulses", ovr_cnt - o0, 32'h1);
        drain(16);
        check("ovr_drained", {27'h0, fifo_count}, 32'h0);
        check("ovr_queue_empty", exp_q.size(), 32'h0);

        // full FIFO with a pop in the exact push cycle of the 17th byte
        o0 = ovr_cnt;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h20 + 8'(i));
            send_frame(8'h20 + 8'(i), 1'b1, 32);
        end
        exp_q.push_back(8'h30);
        fork
            send_frame(8'h30, 1'b1, 32);
            begin
                // push lands on the clock edge 311 cycles after the start edge is driven
                repeat (310) step();
                rx_ready = 1'b1;
                step();
                rx_ready = 1'b0;
            end
        join
        idle_bits(1, 32);
        check("fullpp_count", {27'h0, fifo_count}, 32'd16);
        check("fullpp_ovr", ovr_cnt - o0, 32'h0);
        drain(16);
        check("fullpp_drained", {27'h0, fifo_count}, 32'h0);
        check("fullpp_queue_empty", exp_q.size(), 32'h0);

        // reset during data bit 4 of 0xFF
        idle_bits(1, 32);
        fork
            send_frame(8'hFF, 1'b1, 32);
            begin
                repeat (175) step();
                comm_reset = 1'b1;
                step();
                comm_reset = 1'b0;
                @(negedge comm_clock);
                check("midrst_busy", {31'h0, rx_busy}, 32'h0);
                check("midrst_valid", {31'h0, rx_valid}, 32'h0);
                check("midrst_count", {27'h0, fifo_count}, 32'h0);
                check("midrst_data", {24'h0, rx_data}, 32'h0);
                check("midrst_ferr", {31'h0, framing_error}, 32'h0);
                check("midrst_ovr", {31'h0, overrun_error}, 32'h0);
            end
        join
        idle_bits(1, 32);
        check("midrst_nopush", {27'h0, fifo_count}, 32'h0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 32);
        idle_bits(1, 32);
        check("midrst_next_count", {27'h0, fifo_count}, 32'h1);
        check("midrst_next_data", {24'h0, rx_data}, 32'h81);
        drain(2);
        check("final_queue_empty", exp_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
